// File: rtl/pcm_route_pkg.sv
`default_nettype none
// ============================================================================
// pcm_route_pkg
// Shared types, width helpers and constants for the PCM sample-ROM routers.
// Revision: 1.0
// ============================================================================
package pcm_route_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bank-select width; a single-bank build still carries one select bit.
  function automatic int sel_width(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
  endfunction

  localparam int SELW     = sel_width(3);
  localparam int CNTW     = cnt_width(1024);
  localparam int OOR_DATA = 0;

endpackage
`default_nettype wire

// File: rtl/pcm_bank_decode.sv
`default_nettype none
// ============================================================================
// pcm_bank_decode
// Combinational flat-address split into {bank, offset, in_range}.
// Revision: 1.0
// ============================================================================
module pcm_bank_decode
  import pcm_route_pkg::*;
#(
  parameter int NBANKS  = 3,
  parameter int BANK_AW = 22,
  parameter int AW      = 24
) (
  input  logic [AW-1:0]                  addr,
  output logic [sel_width(NBANKS)-1:0]   bank,
  output logic [BANK_AW-1:0]             offset,
  output logic                           in_range
);

  localparam int c_hiw  = AW - BANK_AW;
  localparam int c_selw = sel_width(NBANKS);

  assign offset = addr[BANK_AW-1:0];

  generate
    if (c_hiw > 0) begin : g_multi
      // One spare bit so NBANKS itself is representable in the compare.
      localparam logic [c_hiw:0] c_nbanks = (c_hiw + 1)'(NBANKS);
      logic [c_hiw-1:0] w_hi;

      assign w_hi     = addr[AW-1:BANK_AW];
      assign in_range = ({1'b0, w_hi} < c_nbanks);
      assign bank     = w_hi[c_selw-1:0];
    end else begin : g_single
      assign in_range = 1'b1;
      assign bank     = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pcm_bank_router.sv
`default_nettype none
// ============================================================================
// pcm_bank_router
// Registered handshake router from a flat PCM sample-ROM port to N SDRAM banks.
// Optional one-entry hit cache enabled by defining PCMROUTE_CACHE_EN.
// Revision: 1.0
// ============================================================================
module pcm_bank_router
  import pcm_route_pkg::*;
#(
  parameter int NBANKS      = 3,
  parameter int BANK_AW     = 22,
  parameter int AW          = 24,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      CLK96,
  input  logic                      RESET96,
  input  logic                      REQ,
  input  logic [AW-1:0]             ADDR,
  output logic [DW-1:0]             DOUT,
  output logic                      VALID,
  output logic                      BUSY,
  output logic                      TIMEOUT_ERR,
  output logic [NBANKS-1:0]         BANK_CS,
  output logic [NBANKS*BANK_AW-1:0] BANK_ADDR,
  input  logic [NBANKS-1:0]         BANK_OK,
  input  logic [NBANKS*DW-1:0]      BANK_DOUT
);

  localparam int                c_selw    = sel_width(NBANKS);
  localparam int                c_cntw    = cnt_width(TIMEOUT_CYC);
  localparam logic [c_cntw-1:0] c_cnt_max = c_cntw'(TIMEOUT_CYC);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_selw-1:0]         r_bank;
  logic [NBANKS-1:0]         r_cs;
  logic [NBANKS*BANK_AW-1:0] r_bank_addr;
  logic [c_cntw-1:0]         r_cnt;
  logic [DW-1:0]             r_dout;
  logic                      r_terr;

  logic [c_selw-1:0]         w_bank;
  logic [BANK_AW-1:0]        w_offset;
  logic                      w_in_range;
  logic                      w_ok_sel;
  logic [DW-1:0]             w_bank_data;
  logic                      w_hit;
  logic [DW-1:0]             w_hit_data;
  logic                      w_start;
  logic                      w_oor;
  logic                      w_hit_go;
  logic                      w_abort;
  logic                      w_capture;
  logic                      w_timeout;

  pcm_bank_decode #(
    .NBANKS  (NBANKS),
    .BANK_AW (BANK_AW),
    .AW      (AW)
  ) u_decode (
    .addr     (ADDR),
    .bank     (w_bank),
    .offset   (w_offset),
    .in_range (w_in_range)
  );

  assign w_ok_sel    = BANK_OK[r_bank];
  assign w_bank_data = BANK_DOUT[r_bank*DW +: DW];

`ifdef PCMROUTE_CACHE_EN
  logic          r_cache_vld;
  logic [AW-1:0] r_cache_tag;
  logic [DW-1:0] r_cache_data;
  logic [AW-1:0] r_addr;

  assign w_hit      = r_cache_vld && (ADDR == r_cache_tag);
  assign w_hit_data = r_cache_data;

  // Only genuine bank data is cached; a timeout poisons the entry.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_cache_vld  <= 1'b0;
      r_cache_tag  <= '0;
      r_cache_data <= '0;
      r_addr       <= '0;
    end else begin
      if (w_start) r_addr <= ADDR;
      if (w_capture) begin
        r_cache_vld  <= 1'b1;
        r_cache_tag  <= r_addr;
        r_cache_data <= w_bank_data;
      end
      if (w_timeout) r_cache_vld <= 1'b0;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge CLK96) begin
    if (RESET96) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_oor       = 1'b0;
    w_hit_go    = 1'b0;
    w_abort     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (REQ) begin
          if (w_hit) begin
            w_hit_go    = 1'b1;
            w_state_nxt = RESP;
          end else if (w_in_range) begin
            w_start     = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_oor       = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        // r_cnt == 0 marks the first WAIT cycle, where OK may be stale.
        if (!REQ) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if ((r_cnt != '0) && w_ok_sel) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == c_cnt_max) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      r_bank      <= '0;
      r_cs        <= '0;
      r_bank_addr <= '0;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_terr      <= 1'b0;
    end else begin
      if (w_start) begin
        r_bank                              <= w_bank;
        r_cnt                               <= '0;
        r_bank_addr[w_bank*BANK_AW +: BANK_AW] <= w_offset;
        for (int i = 0; i < NBANKS; i++) begin
          r_cs[i] <= (w_bank == c_selw'(i));
        end
      end else if ((r_state == WAIT) && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cntw'(1);
      end
      if (w_abort || w_capture || w_timeout) r_cs <= '0;
      if (w_capture) r_dout <= w_bank_data;
      if (w_timeout) begin
        r_dout <= '0;
        r_terr <= 1'b1;
      end
      if (w_oor)    r_dout <= DW'(OOR_DATA);
      if (w_hit_go) r_dout <= w_hit_data;
    end
  end

  assign DOUT        = r_dout;
  assign VALID       = (r_state == RESP);
  assign BUSY        = (r_state != IDLE);
  assign TIMEOUT_ERR = r_terr;
  assign BANK_CS     = r_cs;
  assign BANK_ADDR   = r_bank_addr;

endmodule
`default_nettype wire

// File: doc/pcm_bank_router.md
Name: pcm_bank_router

Overview:
- Registered request router between a PCM sound chip's flat sample-ROM read port and N independent SDRAM bank ports.
- Replaces combinational bank decode with a handshake-correct state machine.
- Adds stale-OK rejection, abort handling, timeout recovery, and an optional one-entry hit cache.
- Sits between the YMZ280B-class ROM interface and the SDRAM bank slots in each sound subsystem.

Parameters:
- NBANKS, 3: number of SDRAM bank ports (1..8).
- BANK_AW, 22: address width of each bank port.
- AW, 24: flat input address width; must satisfy AW >= BANK_AW + clog2(NBANKS).
- DW, 8: data width.
- TIMEOUT_CYC, 1024: maximum WAIT cycles before a forced response.

Ports:
- CLK96  in  1  sole clock.
- RESET96  in  1  reset; synchronous and active-high.
- REQ  in  1  read request level; held with ADDR stable until VALID.
- ADDR  in  AW  flat sample address.
- DOUT  out  DW  response data; holds last value.
- VALID  out  1  one-cycle response strobe.
- BUSY  out  1  high outside IDLE.
- TIMEOUT_ERR  out  1  sticky; set on any timeout.
- BANK_CS  out  NBANKS  one-hot bank chip select.
- BANK_ADDR  out  NBANKS*BANK_AW  per-bank address, packed; bank i occupies slice i.
- BANK_OK  in  NBANKS  per-bank data-ready.
- BANK_DOUT  in  NBANKS*DW  per-bank data, packed.

Behaviour:
- Reset (synchronous, RESET96=1 at an edge):
  - State = IDLE.
  - BANK_CS=0, VALID=0, BUSY=0, DOUT=0, TIMEOUT_ERR=0.
  - All BANK_ADDR=0.
  - Cache invalidated.
  - Reset mid-transaction aborts it with no VALID.
- Decode:
  - bank = ADDR >> BANK_AW; offset = ADDR[BANK_AW-1:0].
  - In range iff bank < NBANKS.
- IDLE:
  - REQ=1 latches ADDR and decodes.
  - In range: next state WAIT. BANK_CS[bank]=1 and BANK_ADDR[bank]=offset, both registered, so they appear in cycle 1.
  - Out of range: next state RESP with data 0.
- WAIT:
  - BANK_OK[bank] is ignored in the first WAIT cycle (stale-OK guard).
  - Thereafter, OK sampled high captures BANK_DOUT[bank] into DOUT and moves to RESP.
  - Minimum latency: REQ at cycle 0, VALID at cycle 3.
- Abort: REQ=0 during WAIT drops CS, returns to IDLE, no VALID, DOUT unchanged.
- Timeout:
  - The counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT_CYC without OK: DOUT=0, TIMEOUT_ERR=1, go to RESP.
  - OK arriving on the same cycle as timeout wins; the data is captured and no error is flagged.
- RESP:
  - VALID=1 for exactly one cycle; BANK_CS drops on that same cycle; next state IDLE.
  - REQ still high in the following IDLE cycle starts a new transaction from the current ADDR.
- Address hold:
  - BANK_ADDR slices change only when that bank is selected.
  - Non-selected slices hold their values.
  - Only one CS bit is ever high.
- Counter width: clog2(TIMEOUT_CYC+1); saturates, never wraps.

Optional Feature:
- Macro: PCMROUTE_CACHE_EN.
- With the macro defined:
  - A one-entry {tag, data, valid} cache is kept.
  - IDLE with REQ=1 and ADDR==tag (valid) goes directly to RESP: VALID at cycle 1, no BANK_CS.
  - Every successful bank read loads the entry.
  - Timeout and out-of-range responses do not load it; a timeout invalidates it.
- Without the macro: no cache storage; every in-range request goes through WAIT.

Decomposition:
- Package pcm_route_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - clog2-derived localparams: SELW, CNTW.
  - Out-of-range data constant: 0.
- Sub-module pcm_bank_decode:
  - Parametrised combinational ADDR -> {bank, offset, in_range}.
  - Also used by the other sound cores' routers.

Test Plan:
- NBANKS=3, ADDR=0x412345, BANK_OK[1] high 4 cycles after CS, BANK_DOUT[1]=0xA5:
  - BANK_CS=3'b010 and BANK_ADDR[1]=0x012345 from cycle 1.
  - VALID one cycle after OK, DOUT=0xA5; other BANK_ADDR slices unchanged.
- ADDR=0xC00010: VALID at cycle 1, DOUT=0x00, BANK_CS never asserted, TIMEOUT_ERR=0.
- BANK_OK[0] held high (stale) before REQ at ADDR=0x000100:
  - OK ignored in the first WAIT cycle; VALID at cycle 3, not cycle 2.
- TIMEOUT_CYC=16, BANK_OK never rises, ADDR=0x800000:
  - VALID at cycle 18, DOUT=0x00, TIMEOUT_ERR=1 and remaining 1 after further good reads.
- REQ dropped in cycle 2 of WAIT: BANK_CS low next cycle, no VALID; a subsequent REQ completes normally.
- RESET96 pulsed mid-WAIT: all outputs at reset values next cycle.
- PCMROUTE_CACHE_EN: two back-to-back reads of 0x412345 -> second read gives VALID at cycle 1 with 0xA5 and no BANK_CS.
